// File: rtl/ivl_uvm_cap_pkg.sv
// ivl_uvm_cap_pkg: shared FSM state type and overflow saturation limit for ivl_uvm_mon_capture
package ivl_uvm_cap_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cap_state_t;
  localparam logic [7:0] OVF_MAX = 8'd255;
endpackage

// File: rtl/ivl_uvm_cap_fifo.sv
// ivl_uvm_cap_fifo: circular capture buffer; push/pop (a pop frees a slot for a same-cycle push when full), din/dout entry, count/full/empty occupancy; dout reads 0 when empty
module ivl_uvm_cap_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/ivl_uvm_mon_capture.sv
// ivl_uvm_mon_capture: passive bus-beat capture buffer (IDLE/RUN/DRAIN FSM, saturating drop counter, timestamps when IVL_UVM_CAP_TS_EN is defined); in: clk, rst_n, cap_en, bus_valid/bus_ready/bus_data, rd_en; out: rd_valid/rd_data/rd_ts, count, ovf_cnt, state_o
module ivl_uvm_mon_capture
  import ivl_uvm_cap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_en,
  input  logic                   bus_valid,
  input  logic                   bus_ready,
  input  logic [DATA_W-1:0]      bus_data,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [TS_W-1:0]        rd_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             ovf_cnt,
  output logic [1:0]             state_o
);
`ifdef IVL_UVM_CAP_TS_EN
  localparam int EW = DATA_W + TS_W;
`else
  localparam int EW = DATA_W;
`endif
  cap_state_t state;
  logic full, empty, push, pop;
  logic [EW-1:0] din, dout;
  assign push     = state == RUN && bus_valid && bus_ready;
  assign pop      = rd_en && !empty;
  assign rd_valid = !empty;
  assign state_o  = state;
`ifdef IVL_UVM_CAP_TS_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ts <= '0;
    else ts <= ts + 1'b1;
  assign din = {bus_data, ts};
  assign {rd_data, rd_ts} = dout;
`else
  assign din     = bus_data;
  assign rd_data = dout;
  assign rd_ts   = '0;
`endif
  ivl_uvm_cap_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_cnt <= '0;
    else if (push && full && !pop && ovf_cnt != OVF_MAX) ovf_cnt <= ovf_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state == IDLE ? (cap_en ? RUN : IDLE) :
                  state == RUN  ? (cap_en ? RUN : DRAIN) :
                  cap_en ? RUN : (empty ? IDLE : DRAIN);
endmodule

// File: tb/tb_ivl_uvm_mon_capture.sv
// tb_ivl_uvm_mon_capture: scoreboard bench for ivl_uvm_mon_capture (default parameters, either IVL_UVM_CAP_TS_EN setting)
module tb_ivl_uvm_mon_capture;
  logic clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0, bus_valid = 1'b0, bus_ready = 1'b0, rd_en = 1'b0;
  logic [31:0] bus_data = '0;
  logic rd_valid;
  logic [31:0] rd_data;
  logic [15:0] rd_ts;
  logic [3:0] count;
  logic [7:0] ovf_cnt;
  logic [1:0] state_o;
  int tests = 0, fails = 0;
  logic [47:0] q[$];
  logic [1:0] m_st = 2'd0;
  logic [7:0] m_ovf = 8'd0;
  logic [15:0] m_ts;

  ivl_uvm_mon_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    (cap_en),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ts     (rd_ts),
    .count     (count),
    .ovf_cnt   (ovf_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n) m_ts <= !rst_n ? 16'd0 : m_ts + 16'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [47:0] h;
    h = q.size() != 0 ? q[0] : 48'd0;
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(q.size() != 0));
    chk({tag, ".rd_data"}, 64'(rd_data), 64'(h[47:16]));
`ifdef IVL_UVM_CAP_TS_EN
    chk({tag, ".rd_ts"}, 64'(rd_ts), 64'(h[15:0]));
`else
    chk({tag, ".rd_ts"}, 64'(rd_ts), 64'd0);
`endif
    chk({tag, ".state"}, 64'(state_o), 64'(m_st));
    chk({tag, ".ovf"}, 64'(ovf_cnt), 64'(m_ovf));
  endtask

  task automatic cycle(input string tag, input logic c, input logic v, input logic rdy,
                       input logic [31:0] d, input logic r, input logic do_chk);
    logic pop, beat, wr;
    logic [1:0] nst;
    logic [7:0] novf;
    cap_en = c; bus_valid = v; bus_ready = rdy; bus_data = d; rd_en = r;
    pop  = r && q.size() != 0;
    beat = m_st == 2'd1 && v && rdy;
    wr   = beat && (q.size() < 8 || pop);
    novf = (beat && !wr && m_ovf != 8'd255) ? m_ovf + 8'd1 : m_ovf;
    nst  = m_st == 2'd0 ? (c ? 2'd1 : 2'd0) :
           m_st == 2'd1 ? (c ? 2'd1 : 2'd2) :
           c ? 2'd1 : (q.size() == 0 ? 2'd0 : 2'd2);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (wr) q.push_back({d, m_ts});
    m_st = nst;
    m_ovf = novf;
    @(negedge clk);
    if (do_chk) check_all(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    cycle("idle_beat", 0, 1, 1, 32'h11, 0, 1);
    cycle("enable", 1, 0, 1, 32'h0, 0, 1);
    cycle("a1", 1, 1, 1, 32'hA1, 0, 1);
    cycle("a2", 1, 1, 1, 32'hA2, 0, 1);
    cycle("a3", 1, 1, 1, 32'hA3, 0, 1);
    cycle("not_ready", 1, 1, 0, 32'hEE, 0, 1);
    chk("three_beats.count", 64'(count), 64'd3);
    chk("three_beats.head", 64'(rd_data), 64'hA1);
    for (int i = 0; i < 3; i++) cycle("pop_a", 1, 0, 1, 32'h0, 1, 1);
    cycle("pop_empty", 1, 0, 1, 32'h0, 1, 1);
    for (int i = 1; i <= 10; i++) cycle("fill", 1, 1, 1, 32'h100 + 32'(i), 0, 1);
    chk("overflow.count", 64'(count), 64'd8);
    chk("overflow.ovf", 64'(ovf_cnt), 64'd2);
    chk("overflow.head", 64'(rd_data), 64'h101);
    cycle("full_push_pop", 1, 1, 1, 32'h200, 1, 1);
    chk("full_push_pop.count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) cycle("drain_full", 1, 0, 1, 32'h0, 1, 1);
    cycle("b1", 1, 1, 1, 32'hB1, 0, 1);
    cycle("b2", 1, 1, 1, 32'hB2, 0, 1);
    cycle("cap_off", 0, 0, 1, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("drain_beat", 0, 1, 1, 32'hC0 + 32'(i), 0, 1);
    chk("drain.state", 64'(state_o), 64'd2);
    cycle("drain_pop1", 0, 1, 1, 32'hC8, 1, 1);
    cycle("drain_pop2", 0, 1, 1, 32'hC9, 1, 1);
    cycle("to_idle", 0, 0, 1, 32'h0, 0, 1);
    chk("drain_done.state", 64'(state_o), 64'd0);
    cycle("ts_enable", 1, 0, 1, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle("ts_beat", 1, 1, 1, 32'hD0 + 32'(i), 0, 1);
      repeat (3) cycle("ts_gap", 1, 0, 1, 32'h0, 0, 1);
    end
    cycle("ts_pop", 1, 0, 1, 32'h0, 1, 1);
    cycle("ts_pop", 1, 0, 1, 32'h0, 1, 1);
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1, 1, 1, 32'hE0 + 32'(i), 0, 1);
    chk("pre_rst.count", 64'(count), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.count", 64'(count), 64'd0);
    chk("async_rst.rd_valid", 64'(rd_valid), 64'd0);
    chk("async_rst.ovf", 64'(ovf_cnt), 64'd0);
    chk("async_rst.state", 64'(state_o), 64'd0);
    chk("async_rst.rd_data", 64'(rd_data), 64'd0);
    q.delete();
    m_st = 2'd0;
    m_ovf = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_rst");
    cycle("post_rst_beat", 1, 1, 1, 32'hF0, 0, 1);
    cycle("post_rst_run", 1, 1, 1, 32'hF1, 0, 1);
    for (int i = 0; i < 270; i++) cycle("sat", 1, 1, 1, 32'h300 + 32'(i), 0, 0);
    check_all("saturate");
    chk("saturate.ovf", 64'(ovf_cnt), 64'd255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ivl_uvm_mon_capture.md
IVL_UVM_MON_CAPTURE -- requirements
Module: ivl_uvm_mon_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of captured bus payload.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two, >=2), capture buffer entries.
REQ-003 SHALL have parameter TS_W, default 16, timestamp counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cap_en, input, 1, capture enable from the testbench monitor.
REQ-007 SHALL have port bus_valid, input, 1, observed valid of the monitored bus.
REQ-008 SHALL have port bus_ready, input, 1, observed ready of the monitored bus.
REQ-009 SHALL have port bus_data, input, DATA_W, observed payload.
REQ-010 SHALL have port rd_en, input, 1, pop request from the ivl_uvm monitor component.
REQ-011 SHALL have port rd_valid, output, 1, head entry available.
REQ-012 SHALL have port rd_data, output, DATA_W, head entry payload.
REQ-013 SHALL have port rd_ts, output, TS_W, head entry timestamp.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port ovf_cnt, output, 8, dropped-beat counter, saturating at 255.
REQ-016 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-017 A beat SHALL be a cycle with bus_valid && bus_ready sampled at clk rising edge; the monitor never drives the bus.
REQ-018 FSM states SHALL be IDLE(0), RUN(1), DRAIN(2); IDLE->RUN when cap_en=1; RUN->DRAIN when cap_en=0; DRAIN->IDLE when count=0; DRAIN->RUN when cap_en=1.
REQ-019 Beats SHALL be written only in RUN; beats in IDLE or DRAIN SHALL be ignored and not counted as overflow.
REQ-020 A written beat SHALL appear at rd_valid/rd_data one cycle after its sampling edge (latency 1).
REQ-021 rd_valid SHALL equal (count!=0); a pop occurs when rd_en && rd_valid; rd_en with empty buffer SHALL be ignored.
REQ-022 rd_data/rd_ts SHALL be stable while rd_valid=1 and no pop occurs.
REQ-023 Simultaneous write and pop SHALL leave count unchanged, including at full (pop frees a slot, beat accepted).
REQ-024 A beat in RUN with count=DEPTH and no pop SHALL be dropped and ovf_cnt incremented, saturating at 255.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH with no entry lost or duplicated.
REQ-026 Timestamp counter SHALL increment every cycle in any state, wrap at 2^TS_W, and each entry SHALL store its value at the sampling edge.

Reset
REQ-027 rst_n low SHALL immediately set state IDLE, pointers 0, count 0, rd_valid 0, ovf_cnt 0, timestamp 0, rd_data 0, rd_ts 0.
REQ-028 Reset asserted mid-capture SHALL discard all buffered entries; first beat after release is captured only after the IDLE->RUN transition.

Configuration
REQ-029 Macro IVL_UVM_CAP_TS_EN defined SHALL include the timestamp counter and per-entry timestamp storage per REQ-026.
REQ-030 Macro IVL_UVM_CAP_TS_EN undefined SHALL remove the counter and storage and tie rd_ts to 0; all other behaviour identical.

Structure
REQ-031 Package ivl_uvm_cap_pkg SHALL hold the FSM state typedef (IDLE/RUN/DRAIN) and the ovf_cnt saturation constant 8'd255.
REQ-032 Storage SHALL be a sub-module ivl_uvm_cap_fifo (circular buffer, pointers, count, simultaneous push/pop); FSM, timestamp and overflow logic stay in the top.

Verification
REQ-033 cap_en=1, three beats 0xA1,0xA2,0xA3, no rd_en -> count=3, rd_data=0xA1, rd_valid rises one cycle after first beat.
REQ-034 DEPTH=8, RUN, 10 beats no pops -> count=8, ovf_cnt=2, rd_data = first beat; then 8 pops return beats 1..8 in order.
REQ-035 Full buffer, beat and rd_en same cycle -> count stays 8, new beat becomes last entry, ovf_cnt unchanged.
REQ-036 cap_en 1->0 with count=2, beats continue -> state DRAIN, no new writes; after 2 pops state IDLE.
REQ-037 rst_n pulsed low mid-RUN with count=5 -> count=0, rd_valid=0, ovf_cnt=0, state IDLE without waiting for clk edge.
REQ-038 IVL_UVM_CAP_TS_EN defined, beats 4 cycles apart -> consecutive rd_ts differ by 4; undefined -> rd_ts=0 always.
